// File: rtl/ook_frame_keyer.sv
// ook_frame_keyer
// On-off keying frame transmitter. Once the PLL has been locked for LOCK_WAIT
// consecutive cycles, a start request latches a FRAME_BITS payload and keys
// the RF carrier MSB first, BIT_TICKS cycles per bit. A silence of
// GAP_BITS bit periods follows, and then a one-cycle done pulse is issued.
// Loss of lock or reset aborts any frame immediately and without done.
//
// Ports
//   refclk      in   PLL output clock; all logic runs on its rising edge
//   rst         in   synchronous reset, active low
//   pll_locked  in   PLL lock indication, synchronous to refclk
//   start       in   transmit request, sampled every cycle
//   frame_data  in   payload, sampled only when start is accepted
//   ready       out  lock qualified and idle
//   busy        out  frame or post-frame gap in progress
//   carrier_en  out  registered on-off key to the RF stage
//   done        out  one-cycle pulse at normal frame completion
module ook_frame_keyer #(
  parameter int BIT_TICKS  = 10800,
  parameter int FRAME_BITS = 32,
  parameter int GAP_BITS   = 8,
  parameter int LOCK_WAIT  = 1024
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame_data,
  output logic                  ready,
  output logic                  busy,
  output logic                  carrier_en,
  output logic                  done
);

  localparam int TICK_W  = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam int BIT_MAX = (FRAME_BITS > GAP_BITS) ? FRAME_BITS : GAP_BITS;
  localparam int BIT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;
  localparam int LOCK_W  = $clog2(LOCK_WAIT + 1);

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(BIT_TICKS - 1);
  localparam logic [BIT_W-1:0]  FRAME_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0]  GAP_LAST   = BIT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [LOCK_W-1:0] LOCK_FULL  = LOCK_W'(LOCK_WAIT);
  localparam logic [LOCK_W-1:0] LOCK_PRE   = LOCK_W'(LOCK_WAIT - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t                state_reg;
  logic [LOCK_W-1:0]     lock_cnt_reg;
  logic [TICK_W-1:0]     tick_reg;
  logic [BIT_W-1:0]      bit_reg;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [FRAME_BITS-1:0] shift_next;

  // The payload moves toward the MSB; the MSB is always the bit on air.
  assign shift_next = shift_reg << 1;

  always_ff @(posedge refclk) begin
    if (!rst) begin
      state_reg    <= WAIT_LOCK;
      lock_cnt_reg <= '0;
      tick_reg     <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      carrier_en   <= 1'b0;
      busy         <= 1'b0;
      ready        <= 1'b0;
      done         <= 1'b0;
    end else if (!pll_locked) begin
      // Losing lock anywhere abandons the frame silently and restarts qualification.
      state_reg    <= WAIT_LOCK;
      lock_cnt_reg <= '0;
      tick_reg     <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      carrier_en   <= 1'b0;
      busy         <= 1'b0;
      ready        <= 1'b0;
      done         <= 1'b0;
    end else begin
      if (lock_cnt_reg != LOCK_FULL) begin
        lock_cnt_reg <= lock_cnt_reg + LOCK_W'(1);
      end
      done <= 1'b0;

      case (state_reg)
        WAIT_LOCK: begin
          // Leave on the same edge that the counter reaches LOCK_WAIT.
          if (lock_cnt_reg >= LOCK_PRE) begin
            state_reg <= IDLE;
            ready     <= 1'b1;
          end
        end

        IDLE: begin
          // A start during the done cycle is deliberately ignored.
          if (start && !done) begin
            state_reg  <= SEND;
            shift_reg  <= frame_data;
            carrier_en <= frame_data[FRAME_BITS-1];
            tick_reg   <= '0;
            bit_reg    <= '0;
            busy       <= 1'b1;
            ready      <= 1'b0;
          end
        end

        SEND: begin
          if (tick_reg == TICK_LAST) begin
            tick_reg <= '0;
            if (bit_reg == FRAME_LAST) begin
              bit_reg    <= '0;
              carrier_en <= 1'b0;
              if (GAP_BITS == 0) begin
                state_reg <= IDLE;
                busy      <= 1'b0;
                ready     <= 1'b1;
                done      <= 1'b1;
              end else begin
                state_reg <= GAP;
              end
            end else begin
              bit_reg    <= bit_reg + BIT_W'(1);
              shift_reg  <= shift_next;
              carrier_en <= shift_next[FRAME_BITS-1];
            end
          end else begin
            tick_reg <= tick_reg + TICK_W'(1);
          end
        end

        GAP: begin
          // The gap reuses the tick/bit counters to time whole bit periods.
          if (tick_reg == TICK_LAST) begin
            tick_reg <= '0;
            if (bit_reg == GAP_LAST) begin
              bit_reg   <= '0;
              state_reg <= IDLE;
              busy      <= 1'b0;
              ready     <= 1'b1;
              done      <= 1'b1;
            end else begin
              bit_reg <= bit_reg + BIT_W'(1);
            end
          end else begin
            tick_reg <= tick_reg + TICK_W'(1);
          end
        end

        default: begin
          state_reg <= WAIT_LOCK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ook_frame_keyer.sv
// tb_ook_frame_keyer
// Self-checking bench for ook_frame_keyer. Two instances share the stimulus:
// one with a post-frame gap of 2 bit periods and one with no gap at all.
// Expected outputs come from a timeline model: each frame is described only
// by the number of edges since it was accepted, from which the carrier bit,
// busy, ready and done follow by plain arithmetic.
module tb_ook_frame_keyer;

  localparam int BIT_TICKS  = 4;
  localparam int FRAME_BITS = 8;
  localparam int GAP_BITS   = 2;
  localparam int LOCK_WAIT  = 16;
  localparam int SEND_LEN   = FRAME_BITS * BIT_TICKS;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       start;
  logic [7:0] frame_data;
  logic       ready_g, busy_g, carrier_g, done_g;
  logic       ready_z, busy_z, carrier_z, done_z;

  ook_frame_keyer #(
    .BIT_TICKS(BIT_TICKS), .FRAME_BITS(FRAME_BITS),
    .GAP_BITS(GAP_BITS), .LOCK_WAIT(LOCK_WAIT)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .start(start),
    .frame_data(frame_data), .ready(ready_g), .busy(busy_g),
    .carrier_en(carrier_g), .done(done_g)
  );

  ook_frame_keyer #(
    .BIT_TICKS(BIT_TICKS), .FRAME_BITS(FRAME_BITS),
    .GAP_BITS(0), .LOCK_WAIT(LOCK_WAIT)
  ) dut_nogap (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .start(start),
    .frame_data(frame_data), .ready(ready_z), .busy(busy_z),
    .carrier_en(carrier_z), .done(done_z)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  // Reference model state, index 0 = gap instance, 1 = no-gap instance.
  int         lock_run;
  bit         qualified;
  int         t_m[2];
  logic [7:0] fd_m[2];
  bit         dn_m[2];
  logic       e_rdy[2], e_bsy[2], e_car[2], e_dn[2];
  int         high_cnt;

  task automatic model_edge(input logic r, input logic l, input logic s, input logic [7:0] d);
    bit was_q;
    if (!r || !l) begin
      lock_run  = 0;
      qualified = 0;
      for (int m = 0; m < 2; m++) begin
        t_m[m] = -1; dn_m[m] = 0;
        e_rdy[m] = 0; e_bsy[m] = 0; e_car[m] = 0; e_dn[m] = 0;
      end
    end else begin
      was_q = qualified;
      if (lock_run < LOCK_WAIT) lock_run++;
      if (lock_run >= LOCK_WAIT) qualified = 1;
      for (int m = 0; m < 2; m++) begin
        int  total;
        bit  nd;
        total = SEND_LEN + ((m == 0) ? GAP_BITS : 0) * BIT_TICKS;
        nd = 0;
        if (t_m[m] >= 0) begin
          t_m[m]++;
          if (t_m[m] == total) begin
            t_m[m] = -1;
            nd = 1;
          end
        end else if (was_q && s && !dn_m[m]) begin
          t_m[m]  = 0;
          fd_m[m] = d;
        end
        dn_m[m]  = nd;
        e_dn[m]  = nd;
        e_bsy[m] = (t_m[m] >= 0);
        e_rdy[m] = qualified && (t_m[m] < 0);
        e_car[m] = (t_m[m] >= 0 && t_m[m] < SEND_LEN) ?
                   fd_m[m][FRAME_BITS - 1 - t_m[m] / BIT_TICKS] : 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic s, input logic [7:0] d);
    rst = r; pll_locked = l; start = s; frame_data = d;
    @(posedge refclk);
    model_edge(r, l, s, d);
    @(negedge refclk);
    cyc++;
    chk("gap.ready",   ready_g,   e_rdy[0]);
    chk("gap.busy",    busy_g,    e_bsy[0]);
    chk("gap.carrier", carrier_g, e_car[0]);
    chk("gap.done",    done_g,    e_dn[0]);
    chk("nogap.ready",   ready_z,   e_rdy[1]);
    chk("nogap.busy",    busy_z,    e_bsy[1]);
    chk("nogap.carrier", carrier_z, e_car[1]);
    chk("nogap.done",    done_z,    e_dn[1]);
    if (carrier_g === 1'b1) high_cnt++;
  endtask

  task automatic run(input int n, input logic s, input logic [7:0] d);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, s, d);
  endtask

  initial begin
    logic [7:0] rd;
    rst = 0; pll_locked = 1; start = 0; frame_data = '0;
    lock_run = 0; qualified = 0; high_cnt = 0;
    for (int m = 0; m < 2; m++) begin t_m[m] = -1; dn_m[m] = 0; end

    // Reset state, then lock qualification with pll_locked held high.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8'hFF);
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'h00);
      chk("ready_at_16", ready_g, (i >= LOCK_WAIT) ? 1'b1 : 1'b0);
    end

    // Single A5 frame followed by gap and done.
    step(1'b1, 1'b1, 1'b1, 8'hA5);
    run(45, 1'b0, 8'h00);

    // start held through the frame: one frame, then a second after done.
    high_cnt = 0;
    run(SEND_LEN + GAP_BITS * BIT_TICKS + 1, 1'b1, 8'hFF);
    chk("ff_high_32", (high_cnt == SEND_LEN) ? 1'b1 : 1'b0, 1'b1);
    run(50, 1'b1, 8'hFF);
    run(50, 1'b0, 8'h00);

    // Lock drop during bit 3 of a frame.
    step(1'b1, 1'b1, 1'b1, 8'h3C);
    run(13, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    run(20, 1'b0, 8'h00);

    // Lock glitch at count 15 delays qualification.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    run(15, 1'b1, 8'h5A);
    step(1'b1, 1'b0, 1'b1, 8'h5A);
    run(20, 1'b0, 8'h00);

    // Reset pulse mid-SEND, start held during requalification.
    step(1'b1, 1'b1, 1'b1, 8'hC3);
    run(10, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'hC3);
    run(20, 1'b1, 8'h96);
    run(45, 1'b0, 8'h00);

    // Randomized traffic with occasional lock loss and reset.
    for (int i = 0; i < 2500; i++) begin
      rd = 8'($urandom);
      step(($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1,
           ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1,
           ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
           rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
